// File: rtl/layer_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_seq_if
//  Purpose  : Bundles the control-slave handshake and the three sub-block
//             start/done handshakes of the layer sequencer.
//  Modports : master - the sequencer (consumes ap_start/layer_num/num_tiles
//                      and the done inputs; drives ap_*, start pulses,
//                      cur_layer, tile_idx, err)
//             slave  - the surrounding system (control slave + DMAs + conv)
//  Revision : 1.0  initial release
// ============================================================================
interface layer_seq_if #(
  parameter int TILE_W = 8
);
  // control slave side
  logic              ap_start;
  logic [7:0]        layer_num;
  logic [TILE_W-1:0] num_tiles;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  // sub-block handshakes
  logic              dma_rd_start;
  logic              dma_rd_done;
  logic              conv_start;
  logic              conv_done;
  logic              dma_wr_start;
  logic              dma_wr_done;
  // status
  logic [7:0]        cur_layer;
  logic [TILE_W-1:0] tile_idx;
  logic              err;

  modport master (
    input  ap_start, layer_num, num_tiles,
    input  dma_rd_done, conv_done, dma_wr_done,
    output ap_ready, ap_done, ap_idle,
    output dma_rd_start, conv_start, dma_wr_start,
    output cur_layer, tile_idx, err
  );

  modport slave (
    output ap_start, layer_num, num_tiles,
    output dma_rd_done, conv_done, dma_wr_done,
    input  ap_ready, ap_done, ap_idle,
    input  dma_rd_start, conv_start, dma_wr_start,
    input  cur_layer, tile_idx, err
  );
endinterface
`default_nettype wire

// File: rtl/layer_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : layer_seq_ctrl
//  Purpose  : Runs one layer as a LOAD -> COMPUTE -> STORE loop over
//             num_tiles tiles, handshaking with read-DMA, conv engine and
//             write-DMA. Reports ap_ready/ap_done/ap_idle to the control
//             slave and guards each phase with a watchdog (sticky err).
//  Ports    : clk     - clock
//             reset   - synchronous, active-high
//             clk_en  - global enable; nothing advances while low
//             bus     - layer_seq_if.master (slave handshake, sub-block
//                       start/done pairs, cur_layer, tile_idx, err)
//  Revision : 1.0  initial release
// ============================================================================
module layer_seq_ctrl #(
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  input  wire logic   clk_en,
  layer_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam bit              c_wd_en   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] c_wd_last = TO_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_first;
  logic [TO_W-1:0]   r_wd;
  logic [TILE_W-1:0] r_tile_idx;
  logic [TILE_W-1:0] r_last_tile;
  logic [7:0]        r_cur_layer;
  logic              r_err;

  logic w_busy;
  logic w_done_in;
  logic w_expire;
  logic w_accept;
  logic w_tile_adv;
  logic w_set_err;
  logic w_entry;

  // Only the done input of the phase we are waiting in counts, and never in
  // the entry cycle (the start pulse is being issued in that cycle).
  always_comb begin
    w_done_in = 1'b0;
    if (!r_first) begin
      case (r_state)
        S_LOAD:  w_done_in = bus.dma_rd_done;
        S_COMP:  w_done_in = bus.conv_done;
        S_STORE: w_done_in = bus.dma_wr_done;
        default: w_done_in = 1'b0;
      endcase
    end
  end

  assign w_busy   = (r_state == S_LOAD) || (r_state == S_COMP) || (r_state == S_STORE);
  assign w_expire = c_wd_en && w_busy && (r_wd == c_wd_last);

  // Next-state logic. An awaited done is tested before expiry so that a done
  // landing in the expiry cycle wins and no error is flagged.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_tile_adv = 1'b0;
    w_set_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ap_start) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_done_in) begin
          w_next = S_COMP;
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_COMP: begin
        if (w_done_in) begin
          w_next = S_STORE;
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_STORE: begin
        if (w_done_in) begin
          if (r_tile_idx == r_last_tile) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_LOAD;
            w_tile_adv = 1'b1;
          end
        end else if (w_expire) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_entry = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b0;
      r_wd        <= '0;
      r_tile_idx  <= '0;
      r_last_tile <= '0;
      r_cur_layer <= '0;
      r_err       <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_next;
      r_first <= w_entry;

      // Watchdog restarts on every state entry, counts only in busy phases.
      if (w_entry) begin
        r_wd <= '0;
      end else if (w_busy) begin
        r_wd <= r_wd + TO_W'(1);
      end

      if (w_accept) begin
        r_cur_layer <= bus.layer_num;
        // A tile count of zero runs a single tile.
        r_last_tile <= (bus.num_tiles == '0) ? '0 : (bus.num_tiles - TILE_W'(1));
        r_tile_idx  <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_tile_adv) begin
          r_tile_idx <= r_tile_idx + TILE_W'(1);
        end
        if (w_set_err) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // All outputs decode registered state, so they hold while clk_en is low.
  assign bus.ap_idle      = (r_state == S_IDLE);
  assign bus.ap_done      = (r_state == S_DONE);
  assign bus.ap_ready     = r_first && (r_state == S_LOAD) && (r_tile_idx == '0);
  assign bus.dma_rd_start = r_first && (r_state == S_LOAD);
  assign bus.conv_start   = r_first && (r_state == S_COMP);
  assign bus.dma_wr_start = r_first && (r_state == S_STORE);
  assign bus.cur_layer    = r_cur_layer;
  assign bus.tile_idx     = r_tile_idx;
  assign bus.err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_layer_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_seq_ctrl
//  Purpose  : Self-checking bench for layer_seq_ctrl. Sub-block responders
//             answer each start after a programmed delay; a timing model
//             predicts every start/ready/done event of a layer from the
//             phase delays and the watchdog limit.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_layer_seq_ctrl;

  localparam int TMO = 16;
  localparam logic [22:0] c_rst_outs = 23'h400000;   // only ap_idle set

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;

  layer_seq_if #(.TILE_W(8)) bus();

  layer_seq_ctrl #(.TILE_W(8), .TIMEOUT(TMO), .TO_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  // event kinds: 0 ready, 1 rd start, 2 conv start, 3 wr start, 4 done
  typedef struct {int c; int k; int t;} ev_t;
  typedef struct {int layer; int nt; int drd; int dcv; int dwr;
                  int off; int err; int nrd; int nwr;} vec_t;

  ev_t obs[$];
  ev_t expq[$];
  int  d_rd[8];
  int  d_cv[8];
  int  d_wr[8];
  int  rd_n, cv_n, wr_n, rd_due, cv_due, wr_due;
  int  cyc = 0;
  int  t0_g = 0;
  int  stray_off = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  function automatic logic [22:0] outs();
    return {bus.ap_idle, bus.ap_ready, bus.ap_done, bus.dma_rd_start,
            bus.conv_start, bus.dma_wr_start, bus.err, bus.tile_idx, bus.cur_layer};
  endfunction

  function automatic int due_of(int n, int d);
    return (n < 8 && d >= 1) ? cyc + d : -1;
  endfunction

  function automatic void resp_clear();
    obs.delete();
    rd_n = 0; cv_n = 0; wr_n = 0;
    rd_due = -1; cv_due = -1; wr_due = -1;
    bus.dma_rd_done = 1'b0;
    bus.conv_done   = 1'b0;
    bus.dma_wr_done = 1'b0;
  endfunction

  // One cycle: sample outputs at the falling edge, log events, answer starts.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.ap_ready) obs.push_back(ev_t'{cyc, 0, int'(bus.tile_idx)});
    if (bus.dma_rd_start) begin
      obs.push_back(ev_t'{cyc, 1, int'(bus.tile_idx)});
      rd_due = due_of(rd_n, (rd_n < 8) ? d_rd[rd_n] : -1); rd_n++;
    end
    if (bus.conv_start) begin
      obs.push_back(ev_t'{cyc, 2, int'(bus.tile_idx)});
      cv_due = due_of(cv_n, (cv_n < 8) ? d_cv[cv_n] : -1); cv_n++;
    end
    if (bus.dma_wr_start) begin
      obs.push_back(ev_t'{cyc, 3, int'(bus.tile_idx)});
      wr_due = due_of(wr_n, (wr_n < 8) ? d_wr[wr_n] : -1); wr_n++;
    end
    if (bus.ap_done) obs.push_back(ev_t'{cyc, 4, int'({bus.err, bus.cur_layer})});
    bus.dma_rd_done = (cyc == rd_due);
    bus.conv_done   = (cyc == cv_due) || (stray_off > 0 && cyc == t0_g + stray_off);
    bus.dma_wr_done = (cyc == wr_due);
  endtask

  // Timing model: each phase lasts d+1 cycles when its done comes d (1..TMO-1)
  // cycles after the start; otherwise the layer ends TMO cycles after phase
  // entry with err set.
  function automatic void model(int T, int layer, int nt);
    int e, last, d;
    expq.delete();
    last = (nt == 0) ? 0 : nt - 1;
    e = T + 1;
    expq.push_back(ev_t'{e, 0, 0});
    for (int tl = 0; tl <= last; tl++) begin
      for (int ph = 1; ph <= 3; ph++) begin
        d = (ph == 1) ? d_rd[tl] : (ph == 2) ? d_cv[tl] : d_wr[tl];
        expq.push_back(ev_t'{e, ph, tl});
        if (d >= 1 && d < TMO) begin
          e += d + 1;
        end else begin
          expq.push_back(ev_t'{e + TMO, 4, 256 + layer});
          return;
        end
      end
    end
    expq.push_back(ev_t'{e, 4, layer});
  endfunction

  task automatic cmp_log();
    chk("ev_count", obs.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      chk($sformatf("ev%0d_cycle", i), obs[i].c, expq[i].c);
      chk($sformatf("ev%0d_kind", i),  obs[i].k, expq[i].k);
      chk($sformatf("ev%0d_tag", i),   obs[i].t, expq[i].t);
    end
  endtask

  function automatic int count_kind(int k);
    int n = 0;
    foreach (obs[i]) if (obs[i].k == k) n++;
    return n;
  endfunction

  task automatic run_layer(input int layer, input int nt, input bit hold,
                           output int t0, output int tdone);
    step();
    chk("idle_before", bus.ap_idle, 1);
    resp_clear();
    t0 = cyc;
    t0_g = t0;
    bus.ap_start  = 1'b1;
    bus.layer_num = 8'(layer);
    bus.num_tiles = 8'(nt);
    model(t0, layer, nt);
    tdone = -1;
    for (int i = 0; i < 400 && tdone < 0; i++) begin
      step();
      if (cyc == t0 + 1) begin
        if (!hold) bus.ap_start = 1'b0;
        chk("accept", {bus.ap_ready, bus.dma_rd_start, bus.ap_idle, bus.err, bus.tile_idx, bus.cur_layer},
                      {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'(layer)});
      end
      if (bus.ap_done === 1'b1) tdone = cyc;
    end
    if (tdone < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_wait: no ap_done within 400 cycles of start at %0d", t0);
    end
    cmp_log();
    if (!hold) begin
      step();
      chk("idle_after", {bus.ap_idle, bus.ap_done}, 2'b10);
    end
  endtask

  vec_t tbl[7];

  initial begin
    int t0, td, ta, tb;
    bus.ap_start = 1'b0; bus.layer_num = '0; bus.num_tiles = '0;
    bus.dma_rd_done = 1'b0; bus.conv_done = 1'b0; bus.dma_wr_done = 1'b0;
    foreach (d_rd[i]) begin d_rd[i] = 1; d_cv[i] = 1; d_wr[i] = 1; end

    tbl[0] = '{3,  1, 2,  2, 2, 10, 0, 1, 1};
    tbl[1] = '{5,  4, 1,  1, 1, 25, 0, 4, 4};
    tbl[2] = '{7,  0, 1,  1, 1,  7, 0, 1, 1};
    tbl[3] = '{9,  2, 3,  1, 2, 19, 0, 2, 2};
    tbl[4] = '{11, 1, 1, 99, 1, 19, 1, 1, 0};
    tbl[5] = '{12, 1, 15, 1, 1, 21, 0, 1, 1};
    tbl[6] = '{13, 1, 16, 1, 1, 17, 1, 1, 0};

    // reset values
    resp_clear();
    repeat (3) step();
    chk("reset_outs", outs(), c_rst_outs);
    reset = 1'b0;

    // table-driven layers
    for (int v = 0; v < 7; v++) begin
      foreach (d_rd[i]) begin d_rd[i] = tbl[v].drd; d_cv[i] = tbl[v].dcv; d_wr[i] = tbl[v].dwr; end
      run_layer(tbl[v].layer, tbl[v].nt, 1'b0, t0, td);
      chk($sformatf("tbl%0d_done_off", v), td - t0, tbl[v].off);
      chk($sformatf("tbl%0d_err", v), bus.err, tbl[v].err);
      chk($sformatf("tbl%0d_n_ready", v), count_kind(0), 1);
      chk($sformatf("tbl%0d_n_rd", v), count_kind(1), tbl[v].nrd);
      chk($sformatf("tbl%0d_n_wr", v), count_kind(3), tbl[v].nwr);
      chk($sformatf("tbl%0d_layer", v), bus.cur_layer, tbl[v].layer);
    end

    // stray conv_done while loading must not move the sequencer
    foreach (d_rd[i]) begin d_rd[i] = 6; d_cv[i] = 1; d_wr[i] = 1; end
    stray_off = 3;
    run_layer(50, 1, 1'b0, t0, td);
    stray_off = 0;

    // auto-restart: ap_start held through the first layer
    foreach (d_rd[i]) begin d_rd[i] = 1; d_cv[i] = 2; d_wr[i] = 1; end
    run_layer(21, 1, 1'b1, t0, ta);
    run_layer(22, 2, 1'b0, tb, td);
    chk("restart_ready_cycle", obs.size() > 0 ? obs[0].c : -1, ta + 2);

    // clk_en low for 5 edges mid-COMP with conv_done withheld
    d_rd[0] = 1; d_cv[0] = -1; d_wr[0] = 1;
    step();
    resp_clear();
    t0 = cyc;
    bus.ap_start = 1'b1; bus.layer_num = 8'd30; bus.num_tiles = 8'd1;
    step();
    bus.ap_start = 1'b0;
    step(); step();
    chk("frz_comp_entry", bus.conv_start, 1);
    step();
    clk_en = 1'b0;
    repeat (5) begin
      step();
      chk("frz_hold", {bus.ap_idle, bus.ap_done, bus.conv_start, bus.cur_layer}, {1'b0, 1'b0, 1'b0, 8'd30});
    end
    clk_en = 1'b1;
    td = -1;
    for (int i = 0; i < 100 && td < 0; i++) begin
      step();
      if (bus.ap_done === 1'b1) td = cyc;
    end
    chk("frz_done_cycle", td - t0, 24);
    chk("frz_err", bus.err, 1);
    step();
    chk("frz_idle_err_held", {bus.ap_idle, bus.err}, 2'b11);

    // reset while storing: immediate abort, no ap_done
    d_rd[0] = 1; d_cv[0] = 1; d_wr[0] = -1;
    run_layer(31, 1, 1'b0, t0, td);   // watchdog layer; also clears err first
    step();
    resp_clear();
    t0 = cyc;
    bus.ap_start = 1'b1; bus.layer_num = 8'd40; bus.num_tiles = 8'd1;
    step();
    bus.ap_start = 1'b0;
    repeat (4) step();
    chk("rst_store_entry", bus.dma_wr_start, 1);
    step();
    reset = 1'b1;
    step();
    chk("rst_store_outs", outs(), c_rst_outs);
    step();
    chk("rst_store_outs2", outs(), c_rst_outs);
    reset = 1'b0;
    step();
    chk("rst_store_after", outs(), c_rst_outs);

    // randomized layers against the timing model
    for (int r = 0; r < 30; r++) begin
      foreach (d_rd[i]) begin
        d_rd[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(1, 6));
        d_cv[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(1, 6));
        d_wr[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(1, 6));
      end
      run_layer(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)), 1'b0, t0, td);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Layer sequencer that sits directly downstream of the AXI-lite control slave. It consumes `ap_start` and `layer_num` and runs one layer as a LOAD → COMPUTE → STORE loop over `num_tiles` tiles, handshaking with the read-DMA, conv engine and write-DMA. It returns `ap_ready`, `ap_done` and `ap_idle` to the slave, and adds a per-phase watchdog with a sticky error flag.

## Interface
Parameters:
- TILE_W, 8, width of tile count and tile index.
- TIMEOUT, 65535, watchdog limit in enabled cycles per phase; 0 disables the watchdog.
- TO_W, 16, watchdog counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  global enable; all state, counters and flags advance only when 1.
- ap_start  in  1  level start from the slave.
- layer_num  in  8  layer id; latched at start.
- num_tiles  in  TILE_W  tile count for the layer; latched at start; 0 is treated as 1.
- ap_ready  out  1  start accepted (inputs consumed).
- ap_done  out  1  layer finished.
- ap_idle  out  1  sequencer in IDLE.
- dma_rd_start  out  1  tile-load request.
- dma_rd_done  in  1  tile-load complete.
- conv_start  out  1  compute request.
- conv_done  in  1  compute complete.
- dma_wr_start  out  1  tile-store request.
- dma_wr_done  in  1  tile-store complete.
- cur_layer  out  8  latched layer_num.
- tile_idx  out  TILE_W  current tile, 0-based.
- err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, LOAD, COMP, STORE, DONE. Register `first` is 1 in the first enabled cycle after any state entry.
- IDLE: `ap_start`=1 latches `layer_num` into `cur_layer`, latches `max(num_tiles,1)-1` as `last_tile`, clears `tile_idx`, clears `err`, then → LOAD.
- LOAD: `dma_rd_start` = `first`. On `dma_rd_done` → COMP.
- COMP: `conv_start` = `first`. On `conv_done` → STORE.
- STORE: `dma_wr_start` = `first`. On `dma_wr_done`:
  - if `tile_idx` == `last_tile` → DONE;
  - otherwise `tile_idx`+1 → LOAD.
- DONE: `ap_done`=1, then unconditionally → IDLE.
- `ap_ready` = `first` & LOAD & (`tile_idx`==0). This is exactly one enabled cycle per layer.
- `ap_idle` = (state==IDLE). This output is combinational from state.
- Done inputs are ignored in the cycle where `first`=1. Sub-blocks must not complete in the same cycle their start is issued.
- Done inputs are ignored in any state other than the one that awaits them. A stray done input causes no transition.
- Watchdog:
  - the counter clears on every state entry and increments each enabled cycle in LOAD, COMP and STORE;
  - on reaching TIMEOUT-1 without the awaited done: `err`←1, → DONE (`ap_done` still pulses);
  - an awaited done arriving in the expiry cycle takes priority: normal transition, no error.
- `err` holds until the next accepted start or reset.
- Auto-restart: if `ap_start` is still 1 when back in IDLE, the next layer starts at once. This gives one IDLE cycle between layers.
- `tile_idx` never wraps. Its maximum value is `last_tile` ≤ 2^TILE_W-1.

## Timing
- Reset: state=IDLE, `ap_idle`=1. All other outputs are 0: `ap_ready`, `ap_done`, the three start signals, `cur_layer`, `tile_idx`, `err`. Counters and `first` are also 0.
- A reset mid-layer aborts immediately with no `ap_done` pulse. Sub-blocks are reset by the same signal.
- Start sequence:
  - `ap_start` sampled 1 in IDLE at edge T;
  - cycle T+1: LOAD, with `ap_ready`=`dma_rd_start`=1 and `ap_idle`=0;
  - the slave drops `ap_start` from T+2 unless auto-restart is set.
- Per-phase latency: the start pulse is in the entry cycle. If done arrives d ≥ 1 cycles later, the next state begins one cycle after done.
- Minimum layer length (1 tile, all d=1): 7 cycles from the start edge to the `ap_done` cycle, plus 1 IDLE cycle.
- `clk_en`=0 freezes everything. Pulse outputs hold their value while frozen, so consumers share the same enable.

## Test plan
- Single tile: `layer_num`=3, `num_tiles`=1, each done 2 cycles after its start. Expect:
  - one `ap_ready`;
  - one each of `dma_rd_start`, `conv_start`, `dma_wr_start`;
  - `ap_done` 10 cycles after the start edge, `cur_layer`=3, `err`=0, `ap_idle`=1 next cycle.
- Multi tile: `num_tiles`=4. Expect 4 LOAD/COMP/STORE rounds, `tile_idx` stepping 0,1,2,3, one `ap_ready`, and one `ap_done` after STORE of tile 3.
- `num_tiles`=0: behaves exactly like `num_tiles`=1.
- Watchdog with TIMEOUT=16: `conv_done` withheld. Expect `err`=1 and `ap_done` 16 cycles after COMP entry, then IDLE. Starting the next layer clears `err`.
- Auto-restart: `ap_start` held high for 2 layers. Expect 2 `ap_done` pulses, 1 IDLE cycle between layers, and `layer_num` re-latched each time.
- Robustness:
  - stray `conv_done` during LOAD: no state change;
  - `clk_en` low for 5 cycles mid-COMP: the state and watchdog counter freeze;
  - reset asserted in STORE: all outputs take their reset values the next cycle, with no `ap_done`.
